// File: rtl/pingpong_fill_scheduler_pkg.sv
// Shared types and defaults for the display ping-pong fill scheduler.
package pingpong_fill_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } fill_state_t;

  localparam logic BUF0 = 1'b0;
  localparam logic BUF1 = 1'b1;

  localparam int DEF_BUF_WORDS = 128;
  localparam int DEF_SM_WORDS  = 128;
  localparam int DEF_AW        = 7;

endpackage

// File: rtl/pingpong_fill_scheduler_if.sv
// Display-side control and SM/buffer strobe bundle for the fill scheduler.
interface pingpong_fill_scheduler_if;

  logic cs_display;
  logic drain_done;
  logic re_sm;
  logic inc_addr_sm;
  logic reset_addr_sm;
  logic we0;
  logic we1;
  logic inc_addr0;
  logic inc_addr1;
  logic reset_addr0;
  logic reset_addr1;
  logic rd_buf;
  logic disp_valid;
  logic underrun;

  modport master (
    output cs_display, drain_done,
    input  re_sm, inc_addr_sm, reset_addr_sm, we0, we1, inc_addr0, inc_addr1,
           reset_addr0, reset_addr1, rd_buf, disp_valid, underrun
  );

  modport slave (
    input  cs_display, drain_done,
    output re_sm, inc_addr_sm, reset_addr_sm, we0, we1, inc_addr0, inc_addr1,
           reset_addr0, reset_addr1, rd_buf, disp_valid, underrun
  );

endinterface

// File: rtl/pingpong_fill_scheduler_flags.sv
// Buffer full flags, display read pointer and underrun detection.
module pingpong_fill_scheduler_flags
  import pingpong_fill_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drain_done,
  input  logic [1:0] set_full,
  output logic [1:0] full,
  output logic       rd_buf,
  output logic       disp_valid,
  output logic       underrun
);

  logic [1:0] full_next;
  logic       other;

  assign other      = ~rd_buf;
  assign disp_valid = full[rd_buf];

  // Drain clears the buffer being read; a completing fill sets its flag in the same cycle.
  always_comb begin
    full_next = full;
    if (drain_done && disp_valid) begin
      full_next[rd_buf] = 1'b0;
    end
    full_next = full_next | set_full;
  end

  // Flag/pointer registers; a fill finishing alongside the drain counts as ready, so no underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      rd_buf   <= BUF0;
      underrun <= 1'b0;
    end else begin
      full     <= full_next;
      underrun <= 1'b0;
      if (drain_done) begin
        if (disp_valid) begin
          rd_buf   <= other;
          underrun <= ~(full[other] | set_full[other]);
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pingpong_fill_scheduler.sv
// Ping-pong fill sequencer: copies SystemMemory words into whichever buffer the display is not reading.
module pingpong_fill_scheduler
  import pingpong_fill_scheduler_pkg::*;
#(
  parameter int BUF_WORDS = DEF_BUF_WORDS,
  parameter int SM_WORDS  = DEF_SM_WORDS,
  parameter int AW        = DEF_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pingpong_fill_scheduler_if.slave pp
);

  if (BUF_WORDS < 1 || SM_WORDS < 1 || BUF_WORDS > (1 << AW) || SM_WORDS > (1 << AW)) begin : g_param_err
    $error("pingpong_fill_scheduler: BUF_WORDS/SM_WORDS must be in 1..2**AW");
  end

  localparam logic [AW-1:0] BUF_LAST = AW'(BUF_WORDS - 1);
  localparam logic [AW-1:0] SM_LAST  = AW'(SM_WORDS - 1);

  fill_state_t   state, state_next;
  logic          tgt;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] sm_cnt;
  logic [1:0]    full;
  logic [1:0]    set_full;
  logic          rd_buf, disp_valid;
  logic          elig0, elig1, sel_valid, sel_buf, load_tgt;
  logic          re_sm, inc_addr_sm, reset_addr_sm;
  logic          we0, we1, inc_addr0, inc_addr1, reset_addr0, reset_addr1;

  pingpong_fill_scheduler_flags u_flags (
    .clk        (clk),
    .rst_n      (rst_n),
    .drain_done (pp.drain_done),
    .set_full   (set_full),
    .full       (full),
    .rd_buf     (rd_buf),
    .disp_valid (disp_valid),
    .underrun   (pp.underrun)
  );

  // The buffer on display is never refilled while it is valid.
  assign elig0 = !full[0] && !(rd_buf == BUF0 && disp_valid);
  assign elig1 = !full[1] && !(rd_buf == BUF1 && disp_valid);

  // Next-state and Moore strobe decode; Buffer0 wins when both are eligible.
  always_comb begin
    state_next    = state;
    sel_valid     = 1'b0;
    sel_buf       = BUF0;
    load_tgt      = 1'b0;
    set_full      = 2'b00;
    re_sm         = 1'b0;
    inc_addr_sm   = 1'b0;
    reset_addr_sm = 1'b0;
    we0           = 1'b0;
    we1           = 1'b0;
    inc_addr0     = 1'b0;
    inc_addr1     = 1'b0;
    reset_addr0   = 1'b0;
    reset_addr1   = 1'b0;
    if (elig0) begin
      sel_valid = 1'b1;
      sel_buf   = BUF0;
    end else if (elig1) begin
      sel_valid = 1'b1;
      sel_buf   = BUF1;
    end
    case (state)
      ST_IDLE: begin
        if (pp.cs_display) state_next = ST_SEL;
      end
      ST_SEL: begin
        if (!pp.cs_display) begin
          state_next = ST_IDLE;
        end else if (sel_valid) begin
          load_tgt    = 1'b1;
          reset_addr0 = (sel_buf == BUF0);
          reset_addr1 = (sel_buf == BUF1);
          state_next  = ST_RD;
        end
      end
      ST_RD: begin
        re_sm      = 1'b1;
        state_next = ST_WR;
      end
      ST_WR: begin
        we0       = (tgt == BUF0);
        we1       = (tgt == BUF1);
        inc_addr0 = (tgt == BUF0);
        inc_addr1 = (tgt == BUF1);
        if (sm_cnt == SM_LAST) reset_addr_sm = 1'b1;
        else                   inc_addr_sm   = 1'b1;
        if (word_cnt == BUF_LAST) begin
          set_full[tgt] = 1'b1;
          state_next    = pp.cs_display ? ST_SEL : ST_IDLE;
        end else begin
          state_next    = pp.cs_display ? ST_RD : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, fill target and word/SM counters; a new target always restarts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tgt      <= BUF0;
      word_cnt <= '0;
      sm_cnt   <= '0;
    end else begin
      state <= state_next;
      if (load_tgt) begin
        tgt      <= sel_buf;
        word_cnt <= '0;
      end else if (state == ST_WR) begin
        word_cnt <= word_cnt + AW'(1);
        sm_cnt   <= (sm_cnt == SM_LAST) ? '0 : sm_cnt + AW'(1);
      end
    end
  end

  assign pp.re_sm         = re_sm;
  assign pp.inc_addr_sm   = inc_addr_sm;
  assign pp.reset_addr_sm = reset_addr_sm;
  assign pp.we0           = we0;
  assign pp.we1           = we1;
  assign pp.inc_addr0     = inc_addr0;
  assign pp.inc_addr1     = inc_addr1;
  assign pp.reset_addr0   = reset_addr0;
  assign pp.reset_addr1   = reset_addr1;
  assign pp.rd_buf        = rd_buf;
  assign pp.disp_valid    = disp_valid;

endmodule
